ascii_number_parser: RTL and testbench
======================================

ASCII_NUMBER_PARSER -- requirements
Module: ascii_number_parser

Interface
REQ-001 Parameter NDIG, default 4, is the maximum number of decimal digits per number (legal range 1..7).
REQ-002 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 Port dado_ascii, input, 8 bits: received ASCII character.
REQ-005 Port dado_valido, input, 1 bit: one-cycle strobe qualifying dado_ascii.
REQ-006 Port pronto, output, 1 bit: high when a character can be accepted.
REQ-007 Port numero_bcd, output, 4*NDIG bits: accumulated BCD digits, least-significant digit in [3:0].
REQ-008 Port num_digitos, output, 3 bits: count of digits held (0..NDIG).
REQ-009 Port fim, output, 1 bit: one-cycle pulse on a completed number.
REQ-010 Port erro, output, 1 bit: one-cycle pulse on a rejected sequence.

Function
REQ-011 The FSM has exactly four states: OCIOSO (no digits), ACUMULA (1..NDIG digits), FIM, ERRO.
REQ-012 A character is accepted only when dado_valido=1 and pronto=1; dado_valido while pronto=0 is dropped without side effect.
REQ-013 pronto is 1 in OCIOSO and ACUMULA, and 0 in FIM and ERRO.
REQ-014 Digit 0x30..0x39 with num_digitos<NDIG: numero_bcd shifts left 4 bits, inserts (char-0x30) in [3:0], num_digitos increments, state becomes ACUMULA; all visible after the accepting edge.
REQ-015 The first digit accepted in OCIOSO clears the previous numero_bcd before insertion.
REQ-016 Digit with num_digitos=NDIG (overflow) -> ERRO.
REQ-017 Terminator 0x0D in ACUMULA -> FIM; 0x0D in OCIOSO -> ERRO.
REQ-018 Any other character in OCIOSO or ACUMULA -> ERRO (0x08 excepted when BACKSPACE_EN is defined).
REQ-019 FIM lasts exactly one cycle with fim=1; numero_bcd and num_digitos hold the completed number; next state OCIOSO, and values hold until the next accepted digit.
REQ-020 ERRO lasts exactly one cycle with erro=1; numero_bcd and num_digitos are cleared to 0 on entry; next state OCIOSO.
REQ-021 fim and erro are never high together; total latency from terminator strobe edge to fim high is one cycle.

Reset
REQ-022 reset=1 at a clock edge forces OCIOSO, numero_bcd=0, num_digitos=0, fim=0, erro=0, pronto=1; reset overrides any simultaneous dado_valido, including mid-number and in FIM/ERRO.

Configuration
REQ-023 Macro ASCII_PARSER_BACKSPACE_EN, when defined: 0x08 in ACUMULA shifts numero_bcd right 4 bits (zero fill) and decrements num_digitos, returning to OCIOSO when the count reaches 0; 0x08 in OCIOSO is ignored (no error).
REQ-024 Without ASCII_PARSER_BACKSPACE_EN, 0x08 is an invalid character per REQ-018.

Structure
REQ-025 Shared package holds the state encoding, character constants (ASCII_ZERO=0x30, ASCII_NINE=0x39, ASCII_CR=0x0D, ASCII_BS=0x08) and the invalid-digit code 4'hF.
REQ-026 Sub-module ascii_digit_decoder (combinational): 8-bit input, 4-bit value, 1-bit is_digit; value=4'hF when not a digit; the FSM uses only is_digit for classification.

Verification
REQ-027 Strobes '1','2','3',CR -> fim pulse one cycle after CR, numero_bcd=16'h0123, num_digitos=3, erro never high.
REQ-028 NDIG=4: '9','8','7','6','5' -> erro on the fifth digit, numero_bcd=0, num_digitos=0, then '4',CR -> numero_bcd=16'h0004.
REQ-029 CR alone from OCIOSO -> erro=1 for one cycle; 'A' after '5' -> erro, count cleared.
REQ-030 Strobe '7' during the FIM cycle -> dropped; numero_bcd stays at the completed value.
REQ-031 reset asserted after '4','2' -> next cycle numero_bcd=0, num_digitos=0, pronto=1, no fim.
REQ-032 With ASCII_PARSER_BACKSPACE_EN: '1','2',BS,'5',CR -> numero_bcd=16'h0015; without the macro, BS -> erro.

Source files
------------

// File: rtl/ascii_number_parser_pkg.sv
// Shared definitions for the ASCII decimal number parser: state encoding,
// character constants and the code reported for a non-digit character.
package ascii_number_parser_pkg;

   localparam logic [1:0] OCIOSO  = 2'd0;
   localparam logic [1:0] ACUMULA = 2'd1;
   localparam logic [1:0] FIM     = 2'd2;
   localparam logic [1:0] ERRO    = 2'd3;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_NINE = 8'h39;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_BS   = 8'h08;

   localparam logic [3:0] INVALID_DIGIT = 4'hF;

endpackage

// File: rtl/ascii_number_parser_decoder.sv
// Combinational ASCII decimal digit classifier (module ascii_digit_decoder).
module ascii_digit_decoder
   import ascii_number_parser_pkg::*;
(
   input  logic [7:0] ch,
   output logic [3:0] value,
   output logic       is_digit
);

   always_comb begin
      is_digit = (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);
      // For '0'..'9' the low nibble already equals ch - 0x30.
      value    = is_digit ? ch[3:0] : INVALID_DIGIT;
   end

endmodule

// File: rtl/ascii_number_parser.sv
// Accumulates ASCII decimal digits into BCD until CR; pulses fim or erro.
// Optional ASCII_PARSER_BACKSPACE_EN enables 0x08 as a backspace.
module ascii_number_parser
   import ascii_number_parser_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [7:0]      dado_ascii,
   input  logic            dado_valido,
   output logic            pronto,
   output logic [4*NDIG-1:0] numero_bcd,
   output logic [2:0]      num_digitos,
   output logic            fim,
   output logic            erro
);

   localparam int         BW       = 4 * NDIG;
   localparam logic [2:0] NDIG_MAX = 3'(NDIG);

   logic [1:0]    state;
   logic [3:0]    digit_value;
   logic          is_digit;
   logic          accept;
   logic [BW-1:0] shifted_in;

   ascii_digit_decoder u_decoder (
      .ch       (dado_ascii),
      .value    (digit_value),
      .is_digit (is_digit)
   );

   always_comb begin
      pronto     = (state == OCIOSO) || (state == ACUMULA);
      fim        = (state == FIM);
      erro       = (state == ERRO);
      accept     = dado_valido && pronto;
      shifted_in = (numero_bcd << 4) | BW'(digit_value);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= OCIOSO;
         numero_bcd  <= '0;
         num_digitos <= '0;
      end else begin
         case (state)
            OCIOSO, ACUMULA: begin
               if (accept) begin
                  if (is_digit) begin
                     if (state == OCIOSO) begin
                        // OCIOSO may still show the last completed number.
                        numero_bcd  <= BW'(digit_value);
                        num_digitos <= 3'd1;
                        state       <= ACUMULA;
                     end else if (num_digitos == NDIG_MAX) begin
                        numero_bcd  <= '0;
                        num_digitos <= '0;
                        state       <= ERRO;
                     end else begin
                        numero_bcd  <= shifted_in;
                        num_digitos <= num_digitos + 3'd1;
                     end
                  end else if (dado_ascii == ASCII_CR) begin
                     if (state == ACUMULA) begin
                        state <= FIM;
                     end else begin
                        numero_bcd  <= '0;
                        num_digitos <= '0;
                        state       <= ERRO;
                     end
`ifdef ASCII_PARSER_BACKSPACE_EN
                  end else if (dado_ascii == ASCII_BS) begin
                     if (state == ACUMULA) begin
                        numero_bcd  <= numero_bcd >> 4;
                        num_digitos <= num_digitos - 3'd1;
                        if (num_digitos == 3'd1) state <= OCIOSO;
                     end
`endif
                  end else begin
                     numero_bcd  <= '0;
                     num_digitos <= '0;
                     state       <= ERRO;
                  end
               end
            end
            FIM:     state <= OCIOSO;
            ERRO:    state <= OCIOSO;
            default: state <= OCIOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_ascii_number_parser.sv
// Directed self-checking bench for ascii_number_parser (NDIG=4).
module tb_ascii_number_parser;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  dado_ascii;
   logic        dado_valido;
   logic        pronto;
   logic [15:0] numero_bcd;
   logic [2:0]  num_digitos;
   logic        fim;
   logic        erro;

   int checks = 0;
   int errors = 0;

   ascii_number_parser #(.NDIG(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .dado_ascii  (dado_ascii),
      .dado_valido (dado_valido),
      .pronto      (pronto),
      .numero_bcd  (numero_bcd),
      .num_digitos (num_digitos),
      .fim         (fim),
      .erro        (erro)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] bcd, input logic [2:0] cnt,
                            input logic p, input logic f, input logic e);
      check({tag, ".bcd"},    32'(numero_bcd),  32'(bcd));
      check({tag, ".cnt"},    32'(num_digitos), 32'(cnt));
      check({tag, ".pronto"}, 32'(pronto),      32'(p));
      check({tag, ".fim"},    32'(fim),         32'(f));
      check({tag, ".erro"},   32'(erro),        32'(e));
   endtask

   // Strobe one character for one cycle; returns #1 after the accepting edge.
   task automatic send(input logic [7:0] ch);
      @(negedge clock);
      dado_ascii  = ch;
      dado_valido = 1'b1;
      @(posedge clock);
      #1;
      dado_valido = 1'b0;
   endtask

   task automatic idle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      dado_ascii  = 8'h00;
      dado_valido = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_all("reset", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // '1','2','3',CR
      send("1"); check_all("d1",   16'h0001, 3'd1, 1'b1, 1'b0, 1'b0);
      send("2"); check_all("d12",  16'h0012, 3'd2, 1'b1, 1'b0, 1'b0);
      send("3"); check_all("d123", 16'h0123, 3'd3, 1'b1, 1'b0, 1'b0);
      send(8'h0D); check_all("cr123", 16'h0123, 3'd3, 1'b0, 1'b1, 1'b0);
      idle();      check_all("after_fim", 16'h0123, 3'd3, 1'b1, 1'b0, 1'b0);

      // Overflow on fifth digit, then recovery
      send("9"); check_all("ov9", 16'h0009, 3'd1, 1'b1, 1'b0, 1'b0);
      send("8");
      send("7");
      send("6"); check_all("ov9876", 16'h9876, 3'd4, 1'b1, 1'b0, 1'b0);
      send("5"); check_all("ov_err", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
      idle();    check_all("ov_after", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
      send("4");
      send(8'h0D); check_all("ov_rec", 16'h0004, 3'd1, 1'b0, 1'b1, 1'b0);
      idle();

      // CR alone from OCIOSO
      send(8'h0D); check_all("cr_alone", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
      idle();      check_all("cr_alone_after", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

      // 'A' after '5'
      send("5"); check_all("d5", 16'h0005, 3'd1, 1'b1, 1'b0, 1'b0);
      send("A"); check_all("bad_char", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
      idle();

      // '7' strobed during the FIM cycle is dropped
      send("4");
      send("2");
      send(8'h0D); check_all("fim42", 16'h0042, 3'd2, 1'b0, 1'b1, 1'b0);
      send("7");   check_all("drop7", 16'h0042, 3'd2, 1'b1, 1'b0, 1'b0);
      idle();      check_all("hold42", 16'h0042, 3'd2, 1'b1, 1'b0, 1'b0);

      // First digit after FIM clears the held number
      send("9"); check_all("first_clear", 16'h0009, 3'd1, 1'b1, 1'b0, 1'b0);
      send(8'h0D);
      idle();

      // Reset mid-number overrides a simultaneous strobe
      send("4");
      send("2");
      @(negedge clock);
      reset       = 1'b1;
      dado_ascii  = "3";
      dado_valido = 1'b1;
      @(posedge clock);
      #1;
      dado_valido = 1'b0;
      check_all("reset_mid", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // Reset during FIM
      send("1");
      send(8'h0D);
      check("fim_before_reset", 32'(fim), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      idle();
      check_all("reset_fim", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // Backspace
      send("1");
      send("2");
      send(8'h08);
`ifdef ASCII_PARSER_BACKSPACE_EN
      check_all("bs", 16'h0001, 3'd1, 1'b1, 1'b0, 1'b0);
      send("5");
      send(8'h0D); check_all("bs_fim", 16'h0015, 3'd2, 1'b0, 1'b1, 1'b0);
      idle();
      send(8'h08); check_all("bs_idle", 16'h0015, 3'd2, 1'b1, 1'b0, 1'b0);
`else
      check_all("bs_err", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
      idle();
      check_all("bs_after", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
